// File: rtl/atm_txn_if.sv
// Request/grant/response bundle between two ATM terminals and the transaction arbiter.
// Master = terminal side, slave = arbiter side.
interface atm_txn_if #(
    parameter int BAL_W = 16
);
    logic             req0;
    logic             req1;
    logic [1:0]       op0;
    logic [1:0]       op1;
    logic [3:0]       acc0;
    logic [3:0]       acc1;
    logic [BAL_W-1:0] amt0;
    logic [BAL_W-1:0] amt1;
    logic             gnt0;
    logic             gnt1;
    logic             done0;
    logic             done1;
    logic [1:0]       rsp_status;
    logic [BAL_W-1:0] rsp_balance;
    logic             busy;

    modport master (
        output req0, req1, op0, op1, acc0, acc1, amt0, amt1,
        input  gnt0, gnt1, done0, done1, rsp_status, rsp_balance, busy
    );

    modport slave (
        input  req0, req1, op0, op1, acc0, acc1, amt0, amt1,
        output gnt0, gnt1, done0, done1, rsp_status, rsp_balance, busy
    );
endinterface

// File: rtl/atm_txn_arbiter.sv
// Two-terminal arbiter owning the account balance store; one txn at a time via LOAD/EXEC/WRITE/RESP.
// Latency: req sampled at edge k -> gnt in cycle k+1 -> done in cycle k+4; at most one txn per 5 cycles.
// Backpressure: requester holds req/fields until gnt. ATM_RR_ARB_EN selects round-robin over fixed priority.
module atm_txn_arbiter #(
    parameter int NUM_ACC      = 10,
    parameter int BAL_W        = 16,
    parameter int INIT_BALANCE = 500
) (
    input  logic      clk,
    input  logic      rst,
    atm_txn_if.slave  bus
);

    localparam int         ACC_W   = 4;
    localparam logic [1:0] OP_WD   = 2'b01;
    localparam logic [1:0] OP_DEP  = 2'b10;
    localparam logic [1:0] ST_OK   = 2'b00;
    localparam logic [1:0] ST_INSF = 2'b01;
    localparam logic [1:0] ST_INV  = 2'b10;
    localparam logic [1:0] ST_OVF  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EXEC,
        S_WRITE,
        S_RESP
    } state_t;

    state_t           state;
    logic [BAL_W-1:0] db [NUM_ACC];

    logic             win_q;
    logic [1:0]       op_q;
    logic [ACC_W-1:0] acc_q;
    logic [BAL_W-1:0] amt_q;
    logic [BAL_W-1:0] bal_q;
    logic             acc_ok_q;
    logic [BAL_W-1:0] new_bal_q;
    logic [1:0]       status_q;

    logic             win_sel;
    logic             acc_hit;
    logic [BAL_W-1:0] rd_bal;
    logic [BAL_W:0]   sum;
    logic [1:0]       exec_status;
    logic [BAL_W-1:0] exec_bal;

`ifdef ATM_RR_ARB_EN
    logic last_served;

    // On contention the terminal not served last wins; a lone request always wins.
    always_comb begin
        win_sel = bus.req1;
        if (bus.req0 && bus.req1) begin
            win_sel = ~last_served;
        end
    end
`else
    always_comb begin
        win_sel = ~bus.req0;
    end
`endif

    // Decode the account index against the store; misses read as zero.
    always_comb begin
        acc_hit = 1'b0;
        rd_bal  = '0;
        for (int i = 0; i < NUM_ACC; i++) begin
            if (acc_q == ACC_W'(i)) begin
                acc_hit = 1'b1;
                rd_bal  = db[i];
            end
        end
    end

    always_comb begin
        sum         = {1'b0, bal_q} + {1'b0, amt_q};
        exec_status = ST_OK;
        exec_bal    = bal_q;
        if (!acc_ok_q) begin
            exec_status = ST_INV;
            exec_bal    = '0;
        end else begin
            case (op_q)
                OP_WD: begin
                    if (amt_q > bal_q) begin
                        exec_status = ST_INSF;
                    end else begin
                        exec_bal = bal_q - amt_q;
                    end
                end
                OP_DEP: begin
                    // Carry out of the widened sum means the deposit would wrap.
                    if (sum[BAL_W]) begin
                        exec_status = ST_OVF;
                    end else begin
                        exec_bal = sum[BAL_W-1:0];
                    end
                end
                default: begin
                    exec_status = ST_OK;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= S_IDLE;
            win_q           <= 1'b0;
            op_q            <= '0;
            acc_q           <= '0;
            amt_q           <= '0;
            bal_q           <= '0;
            acc_ok_q        <= 1'b0;
            new_bal_q       <= '0;
            status_q        <= ST_OK;
            bus.gnt0        <= 1'b0;
            bus.gnt1        <= 1'b0;
            bus.done0       <= 1'b0;
            bus.done1       <= 1'b0;
            bus.rsp_status  <= '0;
            bus.rsp_balance <= '0;
            bus.busy        <= 1'b0;
`ifdef ATM_RR_ARB_EN
            last_served     <= 1'b1;
`endif
            for (int i = 0; i < NUM_ACC; i++) begin
                db[i] <= BAL_W'(INIT_BALANCE);
            end
        end else begin
            bus.gnt0  <= 1'b0;
            bus.gnt1  <= 1'b0;
            bus.done0 <= 1'b0;
            bus.done1 <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        win_q    <= win_sel;
                        op_q     <= win_sel ? bus.op1  : bus.op0;
                        acc_q    <= win_sel ? bus.acc1 : bus.acc0;
                        amt_q    <= win_sel ? bus.amt1 : bus.amt0;
                        bus.gnt0 <= ~win_sel;
                        bus.gnt1 <= win_sel;
                        bus.busy <= 1'b1;
`ifdef ATM_RR_ARB_EN
                        last_served <= win_sel;
`endif
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    bal_q    <= rd_bal;
                    acc_ok_q <= acc_hit;
                    state    <= S_EXEC;
                end
                S_EXEC: begin
                    new_bal_q <= exec_bal;
                    status_q  <= exec_status;
                    state     <= S_WRITE;
                end
                S_WRITE: begin
                    if (status_q == ST_OK && (op_q == OP_WD || op_q == OP_DEP)) begin
                        for (int i = 0; i < NUM_ACC; i++) begin
                            if (acc_q == ACC_W'(i)) begin
                                db[i] <= new_bal_q;
                            end
                        end
                    end
                    bus.done0       <= ~win_q;
                    bus.done1       <= win_q;
                    bus.rsp_status  <= status_q;
                    bus.rsp_balance <= new_bal_q;
                    state           <= S_RESP;
                end
                S_RESP: begin
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_atm_txn_arbiter.sv
// Self-checking bench for atm_txn_arbiter: directed vector table, randomized traffic against a
// balance-ledger model, and hand-written arbitration / reset / back-to-back sequences.
module tb_atm_txn_arbiter;

    localparam int NACC = 10;
    localparam int BW   = 16;
    localparam int MAXB = 65535;

    localparam logic [1:0] BAL = 2'b00, WD = 2'b01, DEP = 2'b10, RSV = 2'b11;
    localparam logic [1:0] OK = 2'b00, INSF = 2'b01, INV = 2'b10, OVF = 2'b11;

    logic clk;
    logic rst;

    atm_txn_if #(.BAL_W(BW)) bus ();

    atm_txn_arbiter #(.NUM_ACC(NACC), .BAL_W(BW), .INIT_BALANCE(500)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int mdb [NACC];

    typedef struct {
        int         term;
        logic [1:0] op;
        logic [3:0] acc;
        int         amt;
        logic [1:0] exp_st;
        int         exp_bal;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Ledger model: balances as plain integers, rules straight from the transaction definitions.
    task automatic model_apply(input logic [1:0] op, input int acc, input int amt,
                               output logic [1:0] st, output int bal);
        if (acc >= NACC) begin
            st = INV; bal = 0;
        end else if (op == WD) begin
            if (amt > mdb[acc]) begin
                st = INSF; bal = mdb[acc];
            end else begin
                mdb[acc] = mdb[acc] - amt; st = OK; bal = mdb[acc];
            end
        end else if (op == DEP) begin
            if (mdb[acc] + amt > MAXB) begin
                st = OVF; bal = mdb[acc];
            end else begin
                mdb[acc] = mdb[acc] + amt; st = OK; bal = mdb[acc];
            end
        end else begin
            st = OK; bal = mdb[acc];
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NACC; i++) mdb[i] = 500;
    endtask

    task automatic drive(input int term, input logic r, input logic [1:0] op,
                         input logic [3:0] acc, input int amt);
        if (term == 0) begin
            bus.req0 = r; bus.op0 = op; bus.acc0 = acc; bus.amt0 = BW'(amt);
        end else begin
            bus.req1 = r; bus.op1 = op; bus.acc1 = acc; bus.amt1 = BW'(amt);
        end
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({name, "_ctl"}, {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy}, 0);
        chk({name, "_st"}, bus.rsp_status, 0);
        chk({name, "_bal"}, bus.rsp_balance, 0);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b0;
        drive(0, 1'b0, BAL, 4'd0, 0);
        drive(1, 1'b0, BAL, 4'd0, 0);
        #1;
        chk_outputs_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    // Single transaction from one terminal, started in IDLE; checks latency, exclusivity and busy.
    task automatic do_txn(input int term, input logic [1:0] op, input logic [3:0] acc, input int amt,
                          output logic [1:0] st, output int bal);
        int  lat;
        bit  excl;
        logic g, d, og, od;
        @(negedge clk);
        chk("idle_busy", bus.busy, 0);
        drive(term, 1'b1, op, acc, amt);
        lat  = 0;
        excl = 1'b1;
        st   = 2'b00;
        bal  = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            g = (term == 0) ? bus.gnt0 : bus.gnt1;
            if (g) begin
                lat = i;
                break;
            end
        end
        drive(term, 1'b0, op, acc, amt);
        if (lat == 0) begin
            chk("gnt_timeout", 0, 1);
            return;
        end
        chk("gnt_latency", lat, 1);
        og = (term == 0) ? bus.gnt1 : bus.gnt0;
        chk("gnt_busy", bus.busy, 1);
        if (og) excl = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            d  = (term == 0) ? bus.done0 : bus.done1;
            od = (term == 0) ? bus.done1 : bus.done0;
            if (od || bus.gnt0 || bus.gnt1) excl = 1'b0;
            if (i < 3 && d) excl = 1'b0;
            if (i == 3) begin
                chk("done_latency", d, 1);
                st  = bus.rsp_status;
                bal = int'(bus.rsp_balance);
            end
        end
        chk("exclusive", excl, 1);
    endtask

    vec_t vecs [12];
    logic [1:0] st, est;
    int bal, ebal;
    int exp_g [3];
    int who, seen, lat;
    logic [1:0] rop;
    int racc, ramt, sel;

    initial begin
        rst = 1'b1;
        drive(0, 1'b0, BAL, 4'd0, 0);
        drive(1, 1'b0, BAL, 4'd0, 0);
        #1 rst = 1'b0;
        #3;
        chk_outputs_zero("por");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();

        vecs[0]  = '{0, BAL, 4'd3,  0,     OK,   500};
        vecs[1]  = '{1, WD,  4'd2,  200,   OK,   300};
        vecs[2]  = '{1, WD,  4'd2,  301,   INSF, 300};
        vecs[3]  = '{0, DEP, 4'd0,  65035, OK,   65535};
        vecs[4]  = '{0, DEP, 4'd0,  1,     OVF,  65535};
        vecs[5]  = '{1, BAL, 4'd12, 0,     INV,  0};
        vecs[6]  = '{0, WD,  4'd2,  0,     OK,   300};
        vecs[7]  = '{1, WD,  4'd2,  300,   OK,   0};
        vecs[8]  = '{0, BAL, 4'd2,  0,     OK,   0};
        vecs[9]  = '{1, BAL, 4'd0,  0,     OK,   65535};
        vecs[10] = '{0, RSV, 4'd3,  77,    OK,   500};
        vecs[11] = '{1, WD,  4'd15, 5,     INV,  0};

        for (int v = 0; v < 12; v++) begin
            do_txn(vecs[v].term, vecs[v].op, vecs[v].acc, vecs[v].amt, st, bal);
            chk($sformatf("vec%0d_status", v), st, vecs[v].exp_st);
            chk($sformatf("vec%0d_balance", v), bal, vecs[v].exp_bal);
            model_apply(vecs[v].op, vecs[v].acc, vecs[v].amt, est, ebal);
        end

        for (int n = 0; n < 40; n++) begin
            rop  = 2'($urandom_range(0, 3));
            racc = $urandom_range(0, 11);
            sel  = $urandom_range(0, 3);
            case (sel)
                0:       ramt = $urandom_range(0, 700);
                1:       ramt = $urandom_range(60000, MAXB);
                2:       ramt = $urandom_range(0, 300);
                default: ramt = (racc < NACC) ? mdb[racc] : 0;
            endcase
            do_txn($urandom_range(0, 1), rop, 4'(racc), ramt, st, bal);
            model_apply(rop, racc, ramt, est, ebal);
            chk($sformatf("rnd%0d_status", n), st, est);
            chk($sformatf("rnd%0d_balance", n), bal, ebal);
        end

        // Both terminals requesting continuously for three transactions.
        reset_dut();
`ifdef ATM_RR_ARB_EN
        exp_g = '{0, 1, 0};
`else
        exp_g = '{0, 0, 0};
`endif
        @(negedge clk);
        drive(0, 1'b1, BAL, 4'd1, 0);
        drive(1, 1'b1, BAL, 4'd1, 0);
        for (int t = 0; t < 3; t++) begin
            who = -1;
            for (int i = 1; i <= 20; i++) begin
                @(negedge clk);
                if (bus.gnt0 || bus.gnt1) begin
                    chk("both_gnt_excl", bus.gnt0 & bus.gnt1, 0);
                    who = bus.gnt1 ? 1 : 0;
                    break;
                end
            end
            if (t == 2) begin
                drive(0, 1'b0, BAL, 4'd1, 0);
                drive(1, 1'b0, BAL, 4'd1, 0);
            end
            chk($sformatf("arb_grant%0d", t), who, exp_g[t]);
            repeat (3) @(negedge clk);
            chk($sformatf("arb_done%0d", t), {bus.done1, bus.done0}, (exp_g[t] == 1) ? 2 : 1);
            chk($sformatf("arb_bal%0d", t), bus.rsp_balance, 500);
        end
        drive(0, 1'b0, BAL, 4'd1, 0);
        drive(1, 1'b0, BAL, 4'd1, 0);

        // Reset asserted while a withdraw is in EXEC.
        @(negedge clk);
        drive(0, 1'b1, WD, 4'd5, 100);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.gnt0) begin
                lat = i;
                break;
            end
        end
        chk("inflight_gnt", lat, 1);
        drive(0, 1'b0, WD, 4'd5, 100);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_outputs_zero("inflight_rst");
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.done0 || bus.done1) seen = 1;
        end
        chk("inflight_no_done", seen, 0);
        rst = 1'b1;
        model_reset();
        do_txn(1, BAL, 4'd5, 0, st, bal);
        chk("after_rst_status", st, OK);
        chk("after_rst_balance", bal, 500);

        // Back-to-back deposits to one account from both terminals.
        @(negedge clk);
        drive(0, 1'b1, DEP, 4'd7, 10);
        drive(1, 1'b1, DEP, 4'd7, 10);
        seen = 0;
        for (int t = 0; t < 2; t++) begin
            who = -1;
            lat = 0;
            for (int i = 1; i <= 20; i++) begin
                @(negedge clk);
                if (t == 1 && i == 1) chk("b2b_idle_busy", bus.busy, 0);
                if (bus.gnt0 || bus.gnt1) begin
                    who = bus.gnt1 ? 1 : 0;
                    lat = i;
                    break;
                end
            end
            if (who < 0) begin
                chk("b2b_gnt_timeout", 0, 1);
            end else begin
                drive(who, 1'b0, DEP, 4'd7, 10);
                seen = seen | (1 << who);
                chk("b2b_gnt_busy", bus.busy, 1);
                if (t == 1) chk("b2b_second_gnt_lat", lat, 2);
            end
            repeat (3) @(negedge clk);
            chk($sformatf("b2b_status%0d", t), bus.rsp_status, OK);
            chk($sformatf("b2b_balance%0d", t), bus.rsp_balance, 510 + 10 * t);
            model_apply(DEP, 7, 10, est, ebal);
        end
        drive(0, 1'b0, BAL, 4'd0, 0);
        drive(1, 1'b0, BAL, 4'd0, 0);
        chk("b2b_both_served", seen, 3);
        do_txn(0, BAL, 4'd7, 0, st, bal);
        chk("b2b_final_status", st, OK);
        chk("b2b_final_balance", bal, 520);
        chk("b2b_model_balance", mdb[7], 520);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
